serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per cycle, result and borrow published with a one-cycle done pulse.
// Optional two's-complement overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             borrow,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             r_xmsb;
    logic             r_ymsb;
`endif

    logic w_a;
    logic w_b;
    logic w_diff;
    logic w_bnext;

    assign w_a     = r_a[0];
    assign w_b     = r_b[0];
    assign w_diff  = w_a ^ w_b ^ r_bin;
    assign w_bnext = (~w_a & w_b) | (~(w_a ^ w_b) & r_bin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            z       <= '0;
            borrow  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_xmsb  <= 1'b0;
            r_ymsb  <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts start too, so back-to-back requests lose no cycle
                    if (start) begin
                        r_a     <= x;
                        r_b     <= y;
                        r_res   <= '0;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_xmsb  <= x[WIDTH-1];
                        r_ymsb  <= y[WIDTH-1];
`endif
                        r_state <= S_SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= {w_diff, r_res[WIDTH-1:1]};
                    r_bin <= w_bnext;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        // last bit is still combinational here, fold it straight into z
                        z       <= {w_diff, r_res[WIDTH-1:1]};
                        borrow  <= w_bnext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf     <= (r_xmsb != r_ymsb) && (w_diff != r_xmsb);
`endif
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
